// File: rtl/alu_seq.sv
// alu_seq: registered ALU with iterative multiply/divide.
// Single-cycle ALU ops; mult/div take WIDTH clocks and write HI/LO.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             neg,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SHW:0]       r_cnt;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_a;
  logic               r_negq;
  logic               r_negr;
  logic               r_div0;
  logic               r_done;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_zero;
  logic               r_neg;
  logic               r_ovf;

  logic               w_acc;
  logic               w_mop;
  logic               w_dop;
  logic               w_sop;
  logic               w_last;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rs;
  logic [WIDTH:0]     w_df;
  logic [WIDTH-1:0]   w_nx;
  logic [WIDTH-1:0]   w_ny;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_pf;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  assign w_acc  = (r_state == S_IDLE) && start;
  assign w_mop  = (op == 4'd2) || (op == 4'd3);
  assign w_dop  = (op == 4'd4) || (op == 4'd5);
  assign w_sop  = (op == 4'd2) || (op == 4'd4);
  assign w_last = (r_cnt == (SHW+1)'(1));
  assign w_ma   = (w_sop && a[WIDTH-1]) ? -a : a;
  assign w_mb   = (w_sop && b[WIDTH-1]) ? -b : b;
  assign w_add  = a + b;
  assign w_sub  = a - b;

  // Single-cycle ALU result and signed overflow for add/sub
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (op)
      4'd0: begin
        w_res = w_add;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        w_res = w_sub;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      4'd6:  w_res = a & b;
      4'd7:  w_res = ~(a | b);
      4'd8:  w_res = a | b;
      4'd9:  w_res = a ^ b;
      4'd10: w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd11: w_res = {{(WIDTH-1){1'b0}}, a < b};
      4'd12: w_res = a << b[SHW-1:0];
      4'd13: w_res = a >> b[SHW-1:0];
      4'd14: w_res = $unsigned($signed(a) >>> b[SHW-1:0]);
      default: w_res = '0;
    endcase
  end

  // One shift-add (mult) or restoring-subtract (div) step on magnitudes
  always_comb begin
    w_sum = '0;
    w_rs  = '0;
    w_df  = '0;
    w_nx  = r_x;
    w_ny  = r_y;
    if (r_state == S_MUL) begin
      w_sum = {1'b0, r_x} + (r_y[0] ? {1'b0, r_m} : '0);
      w_nx  = w_sum[WIDTH:1];
      w_ny  = {w_sum[0], r_y[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      w_rs = {r_x, r_y[WIDTH-1]};
      w_df = w_rs - {1'b0, r_m};
      if (!w_df[WIDTH]) begin
        w_nx = w_df[WIDTH-1:0];
        w_ny = {r_y[WIDTH-2:0], 1'b1};
      end else begin
        w_nx = w_rs[WIDTH-1:0];
        w_ny = {r_y[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign w_prod = {w_nx, w_ny};
  assign w_pf   = r_negq ? -w_prod : w_prod;
  assign w_q    = r_negq ? -w_ny : w_ny;
  assign w_r    = r_negr ? -w_nx : w_nx;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: accept only in IDLE, return after WIDTH steps
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_mop)      w_next = S_MUL;
        else if (start && w_dop) w_next = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = r_done;
    out      = r_out;
    hi       = r_hi;
    lo       = r_lo;
    zero     = r_zero;
    neg      = r_neg;
    overflow = r_ovf;
  end

  // Datapath: latch operands, iterate, sign-correct on the final edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_m    <= '0;
      r_a    <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_div0 <= 1'b0;
      r_done <= 1'b0;
      r_out  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_acc) begin
        if (w_mop || w_dop) begin
          r_cnt  <= (SHW+1)'(WIDTH);
          r_x    <= '0;
          r_y    <= w_ma;
          r_m    <= w_mb;
          r_a    <= a;
          r_negq <= w_sop && (a[WIDTH-1] ^ b[WIDTH-1]);
          r_negr <= w_sop && a[WIDTH-1];
          r_div0 <= (b == '0);
          r_ovf  <= 1'b0;
        end else begin
          r_out  <= w_res;
          r_zero <= (w_res == '0);
          r_neg  <= w_res[WIDTH-1];
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
        end
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt - 1'b1;
        r_x   <= w_nx;
        r_y   <= w_ny;
        if (w_last) begin
          r_done <= 1'b1;
          if (r_state == S_MUL) begin
            r_hi <= w_pf[2*WIDTH-1:WIDTH];
            r_lo <= w_pf[WIDTH-1:0];
          end else if (r_div0) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_r;
            r_lo <= w_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq.
// Expected results are queued at issue and compared on done.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        zero;
  logic        neg;
  logic        overflow;

  typedef struct {
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_out, m_hi, m_lo;
  logic        m_z, m_n, m_v;
  int          n_chk = 0;
  int          n_fail = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .out(out),
    .hi(hi), .lo(lo), .zero(zero), .neg(neg),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_out = '0; m_hi = '0; m_lo = '0;
    m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    sb.delete();
  endtask

  task automatic predict(input logic [3:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y);
    logic [31:0] r;
    logic        v;
    longint      p;
    int          sx, sy;
    exp_t        e;
    sx = x;
    sy = y;
    r = '0;
    v = 1'b0;
    case (o)
      4'd0: begin
        r = x + y;
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      4'd1: begin
        r = x - y;
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      4'd2: begin
        p = longint'(sx) * longint'(sy);
        {m_hi, m_lo} = p;
      end
      4'd3: begin
        p = longint'({32'd0, x} * {32'd0, y});
        {m_hi, m_lo} = p;
      end
      4'd4: begin
        if (y == 0) begin
          m_lo = '1; m_hi = x;
        end else if (x == 32'h8000_0000 && y == '1) begin
          m_lo = x; m_hi = '0;
        end else begin
          m_lo = sx / sy; m_hi = sx % sy;
        end
      end
      4'd5: begin
        if (y == 0) begin
          m_lo = '1; m_hi = x;
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
      4'd6:  r = x & y;
      4'd7:  r = ~(x | y);
      4'd8:  r = x | y;
      4'd9:  r = x ^ y;
      4'd10: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd11: r = (x < y) ? 32'd1 : 32'd0;
      4'd12: r = x << y[4:0];
      4'd13: r = x >> y[4:0];
      4'd14: r = sx >>> y[4:0];
      default: r = '0;
    endcase
    if (o inside {4'd2, 4'd3, 4'd4, 4'd5}) begin
      m_v = 1'b0;
    end else begin
      m_out = r;
      m_z = (r == 0);
      m_n = r[31];
      m_v = v;
    end
    e.out = m_out; e.hi = m_hi; e.lo = m_lo;
    e.z = m_z; e.n = m_n; e.v = m_v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("out", out, e.out);
      chk("hi", hi, e.hi);
      chk("lo", lo, e.lo);
      chk("zero", zero, e.z);
      chk("neg", neg, e.n);
      chk("ovf", overflow, e.v);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [3:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input int inj);
    int k;
    int nb;
    bit md;
    bit tmo;
    md = o inside {4'd2, 4'd3, 4'd4, 4'd5};
    op = o; a = x; b = y; start = 1'b1;
    predict(o, x, y);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
    k = 0; nb = 0; tmo = 0;
    @(negedge clk);
    while (!done && !tmo) begin
      if (busy) nb++;
      if (inj >= 0 && k == inj) begin
        start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
      end else if (inj >= 0 && k == inj + 1) begin
        start = 1'b0;
      end
      k++;
      if (k > 40) tmo = 1;
      else @(negedge clk);
    end
    start = 1'b0;
    if (tmo) begin
      chk("timeout", 1, 0);
    end else begin
      chk("latency", k, md ? 32 : 0);
      chk("busy_cycles", nb, md ? 32 : 0);
      chk("busy_at_done", busy, 0);
      pop_cmp();
    end
  endtask

  logic [3:0] alu_ops[8] = '{4'd6, 4'd7, 4'd8, 4'd9,
                             4'd10, 4'd11, 4'd12, 4'd13};
  logic [3:0] b2b_ops[8] = '{4'd0, 4'd1, 4'd6, 4'd7,
                             4'd8, 4'd9, 4'd10, 4'd14};

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_zero", zero, 0);
    chk("rst_neg", neg, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(4'd0, 32'h7FFF_FFFF, 32'd1, -1);
    chk("add_out", out, 32'h8000_0000);
    chk("add_ovf", overflow, 1);
    chk("add_neg", neg, 1);
    do_op(4'd1, 32'd5, 32'd5, -1);
    chk("sub_zero", zero, 1);
    do_op(4'd14, 32'h8000_0000, 32'h24, -1);
    chk("sra_out", out, 32'hF800_0000);
    for (int i = 0; i < 8; i++)
      do_op(alu_ops[i], $urandom, $urandom, -1);
    do_op(4'd10, 32'hFFFF_FFFF, 32'd1, -1);
    do_op(4'd11, 32'hFFFF_FFFF, 32'd1, -1);
    do_op(4'd15, 32'd3, 32'd4, -1);
    chk("rsv_zero", zero, 1);

    do_op(4'd2, -32'sd3, 32'd7, -1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    @(negedge clk);
    chk("done_pulse", done, 0);
    do_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    do_op(4'd4, -32'sd7, 32'd2, -1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    do_op(4'd5, 32'd9, 32'd0, -1);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd9);
    do_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'd0);
    do_op(4'd4, 32'd5, 32'd0, -1);
    do_op(4'd5, 32'hDEAD_BEEF, 32'd13, -1);

    do_op(4'd4, 32'd100, -32'sd7, 5);
    chk("inj_lo", lo, 32'hFFFF_FFF2);
    chk("inj_hi", hi, 32'd2);
    do_op(4'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, -1);
    chk("and_hold_hi", hi, 32'd2);

    @(negedge clk);
    op = 4'd2; a = 32'd1234; b = 32'd5678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(4'd2, -32'sd1234, 32'd5678, -1);

    for (int i = 0; i < 8; i++) begin
      op = b2b_ops[i];
      a = $urandom;
      b = (i == 7) ? 32'd9 : $urandom;
      start = 1'b1;
      predict(op, a, b);
      @(negedge clk);
      chk("b2b_done", done, 1);
      chk("b2b_busy", busy, 0);
      pop_cmp();
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b_end", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the combinational ALU. It registers every result and adds a handshake (`start`/`busy`/`done`). Single-cycle ALU operations complete in one clock. Multiply and divide run iteratively over WIDTH clocks and write persistent HI/LO registers. It sits in the execute stage; the pipeline stalls on `busy`.

## Interface
Parameters:
- WIDTH, 32: operand/result width; ≥ 8, power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from `b`.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  4  0 add, 1 sub, 2 mult, 3 multu, 4 div, 5 divu, 6 and, 7 nor, 8 or, 9 xor, 10 slt, 11 sltu, 12 sll, 13 srl, 14 sra, 15 reserved.
- a  in  WIDTH  operand A (rs; rt for shifts).
- b  in  WIDTH  operand B (rt, immediate, or shift amount), already selected upstream.
- busy  out  1  high while a mult/div is in progress.
- done  out  1  one-cycle pulse when a result is valid.
- out  out  WIDTH  registered ALU result.
- hi, lo  out  WIDTH  registered HI/LO.
- zero, neg, overflow  out  1  registered status flags.

## Operation
- States:
  - IDLE → MUL when start && op∈{2,3}.
  - IDLE → DIV when start && op∈{4,5}.
  - MUL/DIV → IDLE after WIDTH iterations.
  - start is ignored outside IDLE.
- On acceptance, a, b and op are latched. Inputs may change afterwards without effect.
- ALU ops (0,1,6–15):
  - out is written at the accepting edge.
  - zero = (out==0); neg = out[WIDTH-1].
  - overflow is the signed overflow for add/sub and 0 for all other ops.
  - State stays IDLE.
- slt/sltu compare the full operands (signed/unsigned); result is 0 or 1.
- sll/srl/sra shift `a` by b[SHW-1:0]; sra is arithmetic.
- op 15: out=0, zero=1, neg=0, overflow=0, done still pulses.
- Mult/div:
  - out and the flags keep their previous values; overflow is cleared at acceptance.
  - Signed forms operate on magnitudes, then sign-correct at the final edge.
- mult/multu: {hi,lo} = full 2·WIDTH-bit product.
- div/divu, restoring, one quotient bit per clock:
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - Divide by zero (signed and unsigned): lo = all ones, hi = a. Still takes WIDTH clocks.
  - Signed min / −1: lo = min, hi = 0.
- hi/lo change only at mult/div completion. They hold across ALU ops.
- Reset: state=IDLE; busy, done, out, hi, lo, zero, neg, overflow all 0. An in-flight mult/div is aborted and its result discarded.

## Timing
- Edge E0 samples start=1 in IDLE.
- ALU op:
  - out and flags are valid after E0.
  - done=1 for exactly the cycle following E0.
  - busy stays 0.
- Mult/div:
  - busy=1 from after E0 through edge E_WIDTH.
  - At E_WIDTH: hi/lo are written, busy falls, and done=1 for the following cycle.
  - Latency is WIDTH cycles.
- Back-to-back: a start seen in the done cycle (state IDLE) is accepted. ALU ops can therefore issue every cycle, with done held high continuously.
- Iteration counter: SHW+1 bits, loaded with WIDTH at E0, decremented each edge. Completion is when it reaches 0; no wrap-around.
- Reset asserted mid-op: outputs go to 0 immediately (asynchronous). The first accepted start after release begins a fresh operation.

## Test plan
- Single-cycle ALU ops (WIDTH=32):
  - add 0x7FFFFFFF+1 → out=0x80000000, overflow=1, neg=1, done one cycle after start.
  - sub 5−5 → zero=1.
  - sra 0x80000000 by b=0x24 (amount 4) → 0xF8000000.
- mult and multu:
  - mult −3×7 → after 32 cycles of busy, hi=0xFFFFFFFF, lo=0xFFFFFFEB, one done pulse.
  - multu 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide and divide by zero:
  - div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 9/0 → lo=0xFFFFFFFF, hi=9.
  - div 0x80000000/−1 → lo=0x80000000, hi=0.
- Handshake and hold behaviour:
  - Pulse start with an ALU op at cycle 5 of a div → ignored, and the div result is unchanged.
  - An `and` issued in the div's done cycle is accepted; hi/lo are unchanged by it.
- Reset mid-operation: assert reset at cycle 10 of a mult → busy, done, hi, lo go to 0 at once. A new mult after release gives the correct product.
- Back-to-back ALU ops: 8 consecutive ALU ops with start held high → done high for 8 consecutive cycles, and out matches a reference model every cycle.
